// File: rtl/move_sequencer.sv
// Move sequencer: turns player button edges into a queue of one-hot moves and
// sequences a game core through reset, play and end-of-game.
module move_sequencer #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       btn_n_i,
    input  logic       btn_s_i,
    input  logic       btn_e_i,
    input  logic       btn_w_i,
    input  logic       start_i,
    input  logic       d_i,
    input  logic       win_i,
    output logic       game_reset_o,
    output logic       n_o,
    output logic       s_o,
    output logic       e_o,
    output logic       w_o,
    output logic       busy_o,
    output logic       empty_o,
    output logic       full_o,
    output logic       overflow_o,
    output logic [1:0] result_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;
    localparam int unsigned RcW  = $clog2(RESET_CYCLES + 1);

    typedef enum logic [1:0] {
        StIdle,
        StResetGame,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        btn_q;
    logic [RcW-1:0]    rcnt_q, rcnt_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [3:0]        move_q, move_d;
    logic              ovf_q, ovf_d;
    logic [1:0]        result_q, result_d;
    logic [1:0]        mem_q [DEPTH];

    logic [3:0]        btn_now;
    logic [3:0]        rise;
    logic              req_vld;
    logic [1:0]        req_dir;
    logic              flush;
    logic              push_en;
    logic              pop_en;
    logic              do_push;
    logic              do_pop;
    logic              q_empty;
    logic              q_full;

    // Button rising edges, reduced to the single highest-priority request (N > S > E > W).
    always_comb begin
        btn_now = {btn_w_i, btn_e_i, btn_s_i, btn_n_i};
        rise    = btn_now & ~btn_q;
        req_vld = |rise;
        req_dir = 2'd0;
        if (rise[0]) begin
            req_dir = 2'd0;
        end else if (rise[1]) begin
            req_dir = 2'd1;
        end else if (rise[2]) begin
            req_dir = 2'd2;
        end else if (rise[3]) begin
            req_dir = 2'd3;
        end
    end

    // Game FSM: next state, reset countdown, result and queue control strobes.
    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        result_d = result_q;
        flush    = 1'b0;
        push_en  = 1'b0;
        pop_en   = 1'b0;
        if (start_i) begin
            // A new game overrides everything else happening at this edge.
            state_d  = StResetGame;
            rcnt_d   = RcW'(RESET_CYCLES);
            result_d = 2'b00;
            flush    = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StResetGame: begin
                    push_en = 1'b1;
                    rcnt_d  = rcnt_q - RcW'(1);
                    if (rcnt_q <= RcW'(1)) begin
                        // Pop on the entry edge so a queued move drives the first RUN cycle.
                        state_d = StRun;
                        pop_en  = 1'b1;
                    end
                end
                StRun: begin
                    if (d_i || win_i) begin
                        state_d  = StDone;
                        flush    = 1'b1;
                        result_d = d_i ? 2'b10 : 2'b01;
                    end else begin
                        push_en = 1'b1;
                        pop_en  = 1'b1;
                    end
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Queue bookkeeping: pop/push arbitration, overflow and the registered move.
    always_comb begin
        q_empty  = (count_q == '0);
        q_full   = (count_q == CntW'(DEPTH));
        do_pop   = pop_en && !q_empty;
        // A full queue still accepts a push when an entry leaves at the same edge.
        do_push  = push_en && req_vld && (!q_full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        move_d   = 4'b0000;
        if (do_pop) begin
            move_d = 4'b0001 << mem_q[rd_ptr_q];
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            move_d   = 4'b0000;
            if (start_i) begin
                ovf_d = 1'b0;
            end
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
            if (push_en && req_vld && !do_push) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            btn_q    <= 4'b0000;
            rcnt_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            move_q   <= 4'b0000;
            ovf_q    <= 1'b0;
            result_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            btn_q    <= btn_now;
            rcnt_q   <= rcnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            move_q   <= move_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
        end
    end

    // Queue storage; contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= req_dir;
        end
    end

    assign game_reset_o = (state_q == StIdle) || (state_q == StResetGame);
    assign busy_o       = (state_q == StResetGame) || (state_q == StRun);
    assign n_o          = move_q[0];
    assign s_o          = move_q[1];
    assign e_o          = move_q[2];
    assign w_o          = move_q[3];
    assign empty_o      = q_empty;
    assign full_o       = q_full;
    assign overflow_o   = ovf_q;
    assign result_o     = result_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Testbench for move_sequencer: directed scenarios plus random stimulus, all
// checked against a queue-based behavioural model of the game sequencer.
module tb_move_sequencer;

    localparam int Depth     = 8;
    localparam int RstCycles = 10;

    logic       clk_i;
    logic       rst;
    logic [3:0] btn;
    logic       start;
    logic       dead;
    logic       win;

    wire        game_reset, busy, empty, full, overflow;
    wire [3:0]  mv;
    wire [1:0]  result;

    wire        d_game_reset, d_busy, d_empty, d_full, d_overflow;
    wire [3:0]  d_mv;
    wire [1:0]  d_result;

    int n_tests;
    int n_fail;

    // Reference model state
    int       m_q[$];
    bit       m_started;
    bit       m_finished;
    int       m_rst_left;
    bit [3:0] m_prev;
    int       m_move;
    bit       m_ovf;
    bit [1:0] m_result;

    move_sequencer #(
        .DEPTH       (Depth),
        .RESET_CYCLES(RstCycles)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (rst),
        .btn_n_i     (btn[0]),
        .btn_s_i     (btn[1]),
        .btn_e_i     (btn[2]),
        .btn_w_i     (btn[3]),
        .start_i     (start),
        .d_i         (dead),
        .win_i       (win),
        .game_reset_o(game_reset),
        .n_o         (mv[0]),
        .s_o         (mv[1]),
        .e_o         (mv[2]),
        .w_o         (mv[3]),
        .busy_o      (busy),
        .empty_o     (empty),
        .full_o      (full),
        .overflow_o  (overflow),
        .result_o    (result)
    );

    // Default-parameter instance, used for the 4-cycle game-reset scenario.
    move_sequencer dut_dflt (
        .clk_i       (clk_i),
        .reset_i     (rst),
        .btn_n_i     (btn[0]),
        .btn_s_i     (btn[1]),
        .btn_e_i     (btn[2]),
        .btn_w_i     (btn[3]),
        .start_i     (start),
        .d_i         (dead),
        .win_i       (win),
        .game_reset_o(d_game_reset),
        .n_o         (d_mv[0]),
        .s_o         (d_mv[1]),
        .e_o         (d_mv[2]),
        .w_o         (d_mv[3]),
        .busy_o      (d_busy),
        .empty_o     (d_empty),
        .full_o      (d_full),
        .overflow_o  (d_overflow),
        .result_o    (d_result)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_started  = 1'b0;
        m_finished = 1'b0;
        m_rst_left = 0;
        m_prev     = 4'b0000;
        m_move     = -1;
        m_ovf      = 1'b0;
        m_result   = 2'b00;
    endtask

    // One clock edge of the game sequencer, expressed as queue operations.
    task automatic model_edge();
        bit [3:0] rise;
        int       req;
        bit       pop;
        rise   = btn & ~m_prev;
        m_prev = btn;
        req    = -1;
        for (int i = 3; i >= 0; i--) begin
            if (rise[i]) req = i;
        end
        if (start) begin
            m_q.delete();
            m_result   = 2'b00;
            m_ovf      = 1'b0;
            m_started  = 1'b1;
            m_finished = 1'b0;
            m_rst_left = RstCycles;
            m_move     = -1;
        end else if (!m_started || m_finished) begin
            m_move = -1;
        end else if (m_rst_left == 0 && (dead || win)) begin
            m_finished = 1'b1;
            m_q.delete();
            m_move   = -1;
            m_result = dead ? 2'b10 : 2'b01;
        end else begin
            pop = (m_rst_left <= 1) && (m_q.size() > 0);
            if (m_rst_left > 0) m_rst_left--;
            m_move = pop ? m_q.pop_front() : -1;
            if (req >= 0) begin
                if (m_q.size() < Depth) m_q.push_back(req);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        check_val("game_reset", 32'(game_reset), 32'(!m_started || m_rst_left > 0));
        check_val("moves", 32'(mv), (m_move < 0) ? 32'd0 : (32'd1 << m_move));
        check_val("busy", 32'(busy), 32'(m_started && !m_finished));
        check_val("empty", 32'(empty), 32'(m_q.size() == 0));
        check_val("full", 32'(full), 32'(m_q.size() == Depth));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("result", 32'(result), 32'(m_result));
    endtask

    // Inputs are set at the falling edge before calling; outputs checked at the next falling edge.
    task automatic cycle();
        @(posedge clk_i);
        model_edge();
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic wait_run();
        for (int k = 0; k < RstCycles + 4 && m_rst_left != 0; k++) cycle();
    endtask

    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++) begin
            btn = 4'b0001 << (i % 4);
            cycle();
        end
        btn = 4'b0000;
    endtask

    logic       dgr  [8];
    logic [3:0] dmvr [8];
    int         gr_cnt;
    int         pulse_idx;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        btn     = 4'b0000;
        start   = 1'b0;
        dead    = 1'b0;
        win     = 1'b0;
        rst     = 1'b1;
        model_clear();
        #1;
        check_outputs();
        check_val("dflt_reset_game_reset", 32'(d_game_reset), 32'd1);
        check_val("dflt_reset_empty", 32'(d_empty), 32'd1);
        @(posedge clk_i);
        @(negedge clk_i);
        rst = 1'b0;
        check_outputs();

        // Idle ignores button requests
        btn = 4'b0001; cycle();
        btn = 4'b0000; cycle();
        cycle();

        // Game reset length and first-RUN-cycle move on the default instance
        start = 1'b1; cycle(); start = 1'b0;
        for (int j = 0; j < 8; j++) begin
            dgr[j]  = d_game_reset;
            dmvr[j] = d_mv;
            if (j == 1) btn = 4'b0100;
            cycle();
        end
        gr_cnt = 0;
        for (int j = 0; j < 8; j++) if (dgr[j]) gr_cnt++;
        check_val("req032_gr_cycles", 32'(gr_cnt), 32'd4);
        check_val("req032_gr_first", 32'(dgr[3]), 32'd1);
        check_val("req032_e_pulse", 32'(dmvr[4]), 32'b0100);
        check_val("req032_e_single", 32'(dmvr[5]), 32'b0000);
        btn = 4'b0000;
        wait_run();
        cycle(); cycle(); cycle();

        // Simultaneous N and W edges in RUN: only N goes through
        btn = 4'b1001; cycle();
        cycle();
        check_val("req033_n_pulse", 32'(mv), 32'b0001);
        btn = 4'b0000;
        cycle();
        check_val("req033_no_w", 32'(mv), 32'b0000);
        check_val("req033_no_ovf", 32'(overflow), 32'd0);
        cycle();

        // Fill to full, overflow, then drain in FIFO order
        start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            btn = 4'b0001 << (i % 4);
            cycle();
            if (i == 7) begin
                check_val("req034_full", 32'(full), 32'd1);
                check_val("req034_ovf_before", 32'(overflow), 32'd0);
            end
            if (i == 8) check_val("req034_ovf", 32'(overflow), 32'd1);
        end
        btn = 4'b0000;
        pulse_idx = 0;
        for (int k = 0; k < 14; k++) begin
            cycle();
            if (mv != 4'b0000) begin
                check_val("req034_order", 32'(mv), 32'd1 << (pulse_idx % 4));
                pulse_idx++;
            end
        end
        check_val("req034_pulses", 32'(pulse_idx), 32'd8);
        check_val("req034_empty", 32'(empty), 32'd1);

        // dead and win together with moves queued: dead wins
        start = 1'b1; cycle(); start = 1'b0;
        push_burst(4);
        wait_run();
        dead = 1'b1; win = 1'b1; cycle(); dead = 1'b0; win = 1'b0;
        check_val("req035_result", 32'(result), 32'b10);
        check_val("req035_moves", 32'(mv), 32'd0);
        check_val("req035_empty", 32'(empty), 32'd1);
        check_val("req035_busy", 32'(busy), 32'd0);
        cycle();

        // Restart mid-RUN with moves pending: no stale moves afterwards
        start = 1'b1; cycle(); start = 1'b0;
        push_burst(4);
        wait_run();
        cycle();
        start = 1'b1; cycle(); start = 1'b0;
        gr_cnt = 0;
        for (int j = 0; j < RstCycles + 3; j++) begin
            if (game_reset) gr_cnt++;
            check_val("req036_no_stale", 32'(mv), 32'd0);
            check_val("req036_result", 32'(result), 32'd0);
            cycle();
        end
        check_val("req036_gr_cycles", 32'(gr_cnt), 32'(RstCycles));

        // Asynchronous reset between edges while running
        btn = 4'b0001; cycle();
        btn = 4'b0010; cycle();
        btn = 4'b0100;
        @(posedge clk_i);
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_outputs();
        @(negedge clk_i);
        rst = 1'b0;
        check_outputs();
        cycle();

        // Randomized play
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 79) == 0);
            dead  = ($urandom_range(0, 59) == 0);
            win   = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 1) == 0) btn[$urandom_range(0, 3)] = ~btn[$urandom_range(0, 3)];
            if ((i / 500) % 2 == 1) btn[$urandom_range(0, 3)] = ~btn[$urandom_range(0, 3)];
            cycle();
        end
        start = 1'b0;
        dead  = 1'b0;
        win   = 1'b0;
        btn   = 4'b0000;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/move_sequencer.md
MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter DEPTH, default 8, move-queue depth; power of two, minimum 2.
REQ-002 Parameter RESET_CYCLES, default 4, number of cycles the game core is held in reset after start; minimum 1.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_n, btn_s, btn_e, btn_w  input  1 each  player direction buttons, synchronous to clk, level.
REQ-006 start  input  1  single-cycle pulse requesting a new game.
REQ-007 d  input  1  game core "dead" flag.
REQ-008 win  input  1  game core "win" flag.
REQ-009 game_reset  output  1  reset drive to the game core.
REQ-010 n, s, e, w  output  1 each  one-hot move drive to the game core, registered.
REQ-011 busy  output  1  high in RESET_GAME and RUN.
REQ-012 empty, full  output  1 each  move-queue status.
REQ-013 overflow  output  1  sticky flag: a move was dropped because the queue was full.
REQ-014 result  output  2  00 none, 01 win, 10 dead.

Function
REQ-015 The block SHALL register each button every cycle; a move request is btn=1 while its registered previous value is 0 (rising edge).
REQ-016 When several rising edges occur in the same cycle, only the highest-priority one SHALL be requested (priority N > S > E > W); the others are discarded without setting overflow.
REQ-017 Direction encoding in the queue: N=0, S=1, E=2, W=3.
REQ-018 The FSM SHALL have four states: IDLE, RESET_GAME, RUN and DONE.
REQ-019 IDLE: game_reset=1, moves all 0, requests ignored; start -> RESET_GAME.
REQ-020 On any start pulse, in any state including RUN, the block SHALL do all of the following at that edge: flush the queue, clear result, clear overflow, load the cycle counter with RESET_CYCLES, and enter RESET_GAME.
REQ-021 RESET_GAME: game_reset=1 and moves all 0; requests SHALL be enqueued; the counter decrements each cycle; at the edge where the counter reaches 0 -> RUN.
REQ-022 RUN: game_reset=0; requests are enqueued; at each edge where the queue is non-empty, one entry SHALL be popped and its one-hot move registered, so exactly one of n/s/e/w is high for the following cycle. When the queue is empty, all moves are 0.
REQ-023 Latency: a request sampled at edge k is written at edge k. If the block is in RUN and the queue was empty, the entry pops at edge k+1, and the move output is high from edge k+1 to edge k+2.
REQ-024 A move output SHALL never be high for two consecutive cycles from a single request; two identical queued moves produce two consecutive 1-cycle pulses.
REQ-025 RUN: if d or win is 1 at an edge, the FSM SHALL go to DONE, flush the queue and set moves to 0. result SHALL be set to 10 if d=1, otherwise to 01; d has priority when both are 1.
REQ-026 DONE: game_reset=0, moves 0, requests ignored, result held; start -> RESET_GAME; d and win are ignored.
REQ-027 Push while full with no pop in the same cycle: the request SHALL be dropped and overflow set to 1. Push and pop in the same cycle while full: both proceed and the count is unchanged.
REQ-028 Pointers SHALL wrap modulo DEPTH; the count is held in clog2(DEPTH)+1 bits. full = (count==DEPTH); empty = (count==0).
REQ-029 start takes priority over d/win and over enqueue/dequeue occurring in the same cycle.

Reset
REQ-030 On reset assertion the block SHALL immediately (asynchronously) enter IDLE with: game_reset=1, n=s=e=w=0, busy=0, empty=1, full=0, overflow=0, result=00, queue count 0, button history 0.
REQ-031 After reset deasserts, the block SHALL remain in IDLE until start; a button already held at deassertion counts as a rising edge.

Verification
REQ-032 Start, then btn_e rising at cycle 2 of RESET_GAME -> game_reset=1 for exactly 4 cycles, then a single-cycle e pulse in the first RUN cycle.
REQ-033 In RUN with an empty queue, btn_n and btn_w rise in the same cycle -> one n pulse only; no w pulse; overflow=0.
REQ-034 During RESET_GAME, 9 distinct rising edges with DEPTH=8 -> full=1 after the 8th, overflow=1 after the 9th; in RUN, 8 pulses are issued in FIFO order, then empty=1.
REQ-035 In RUN with 3 moves queued, d=1 and win=1 at the same edge -> DONE, result=10, moves 0 next cycle, empty=1, busy=0.
REQ-036 start pulse mid-RUN with 2 moves queued -> queue flushed, game_reset=1 for 4 cycles, result=00, no stale move pulses.
REQ-037 reset asserted mid-RUN between clock edges -> all outputs take the REQ-030 values before the next clock edge.
